// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered execute-stage ALU with a start/busy/done handshake.
//
// Single-cycle ops (add, sub, slt, and, or, xor, nor, divide-by-zero) register
// their result on the edge that samples `start` and pulse `done` in the next
// cycle. Signed multiply and divide run iteratively on operand magnitudes, one
// step per cycle for WIDTH cycles, then apply the sign in a final FIX cycle.
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start    request, sampled only while idle (busy = 0)
//   A, B     signed operands
//   control  with sel = 001: 1 = set-less-than, 0 = subtract
//   sel      000 add, 001 sub/slt, 010 mul, 011 div,
//            100 and, 101 or, 110 xor, 111 nor
//   busy     multi-cycle operation in progress, start is ignored
//   done     one-cycle pulse, res and flags valid from this cycle
//   res      signed result, held until the next done
//   zf       res == 0
//   ovf      signed overflow of add/sub, otherwise 0
//   dz       divide by zero, otherwise 0
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             control,
   input  logic [2:0]       sel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             zf,
   output logic             ovf,
   output logic             dz
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_DIV = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_NOR = 3'b111
   } op_t;

   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   // Control and result registers
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zf_q, zf_d;
   logic             ovf_q, ovf_d;
   logic             dz_q, dz_d;

   // Iterative datapath registers.
   //   mul: x = shifted multiplicand, y = remaining multiplier bits, acc = product
   //   div: x = dividend shifting out / quotient shifting in, y = divisor,
   //        acc = partial remainder
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   // Combinational helpers
   op_t              op;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] sum, diff;
   logic [WIDTH-1:0] mag_a, mag_b, mag_res;
   logic             slt;
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;

   logic [WIDTH-1:0] op_res;
   logic             op_ovf;
   logic             op_dz;
   logic             op_multi;

   assign op      = op_t'(sel);
   assign a_neg   = A[WIDTH-1];
   assign b_neg   = B[WIDTH-1];
   assign sum     = A + B;
   assign diff    = A - B;
   assign slt     = $signed(A) < $signed(B);
   // |MIN| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit magnitude.
   assign mag_a   = a_neg ? -A : A;
   assign mag_b   = b_neg ? -B : B;
   assign mag_res = is_div_q ? x_q : acc_q;

   // Restoring-division step: the partial remainder is always below the
   // divisor, so only the shifted value needs the extra bit.
   assign rem_sh  = {acc_q, x_q[WIDTH-1]};
   assign rem_ge  = rem_sh >= {1'b0, y_q};

   // Result decode for everything that completes in one cycle.
   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      op_res   = '0;
      op_ovf   = 1'b0;
      op_dz    = 1'b0;
      op_multi = 1'b0;
      case (op)
         OP_ADD: begin
            op_res = sum;
            op_ovf = (a_neg == b_neg) && (sum[WIDTH-1] != a_neg);
         end
         OP_SUB: begin
            if (control) begin
               op_res = {{(WIDTH-1){1'b0}}, slt};
            end else begin
               op_res = diff;
               op_ovf = (a_neg != b_neg) && (diff[WIDTH-1] != a_neg);
            end
         end
         OP_MUL: op_multi = 1'b1;
         OP_DIV: begin
            if (B == '0) begin
               op_res = '1;
               op_dz  = 1'b1;
            end else begin
               op_multi = 1'b1;
            end
         end
         OP_AND: op_res = A & B;
         OP_OR:  op_res = A | B;
         OP_XOR: op_res = A ^ B;
         OP_NOR: op_res = ~(A | B);
         default: op_res = '0;
      endcase
   end

   // Next-state and datapath logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      res_d    = res_q;
      zf_d     = zf_q;
      ovf_d    = ovf_q;
      dz_d     = dz_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      x_d      = x_q;
      y_d      = y_q;
      acc_d    = acc_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op_multi) begin
                  state_d  = S_RUN;
                  busy_d   = 1'b1;
                  cnt_d    = '0;
                  is_div_d = (op == OP_DIV);
                  neg_d    = a_neg ^ b_neg;
                  x_d      = mag_a;
                  y_d      = mag_b;
                  acc_d    = '0;
               end else begin
                  res_d  = op_res;
                  ovf_d  = op_ovf;
                  dz_d   = op_dz;
                  done_d = 1'b1;
               end
            end
         end

         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (is_div_q) begin
               x_d   = {x_q[WIDTH-2:0], rem_ge};
               acc_d = rem_ge ? (rem_sh[WIDTH-1:0] - y_q) : rem_sh[WIDTH-1:0];
            end else begin
               acc_d = acc_q + (y_q[0] ? x_q : '0);
               x_d   = {x_q[WIDTH-2:0], 1'b0};
               y_d   = {1'b0, y_q[WIDTH-1:1]};
            end
            if (cnt_q == LAST_STEP) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            // Two's-complement negation of the magnitude also gives the
            // MIN / -1 wrap and the low half of a signed product.
            res_d   = neg_q ? -mag_res : mag_res;
            ovf_d   = 1'b0;
            dz_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Zero flag follows whichever result is being committed.
      if (done_d) begin
         zf_d = (res_d == '0);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
         zf_q    <= 1'b1;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         res_q   <= res_d;
         zf_q    <= zf_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end

   // NOTE: the iterative datapath is left without reset; it is always loaded
   // when an operation starts and is never observed before that.
   always_ff @(posedge clk) begin
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
   end

   assign busy = busy_q;
   assign done = done_q;
   assign res  = res_q;
   assign zf   = zf_q;
   assign ovf  = ovf_q;
   assign dz   = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- scoreboard bench for alu_seq at WIDTH = 32 and WIDTH = 8.
//
// Each width has its own DUT, driver and monitor. The driver walks a list of
// per-cycle stimulus items (directed cases first, then random traffic), keeps
// an abstract model of when a request is accepted, and pushes the expected
// response and its due cycle into a queue. The monitor samples one time unit
// after every rising edge and pops/compares whenever a response is due.
// -----------------------------------------------------------------------------
module tb_alu_seq;

   typedef struct {
      longint res;
      bit     zf;
      bit     ovf;
      bit     dz;
      int     due;
   } exp_t;

   typedef struct {
      bit         rst;
      bit         st;
      longint     a;
      longint     b;
      logic [2:0] sel;
      bit         ctl;
   } item_t;

   logic clk = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   initial forever #5 clk = ~clk;

   task automatic check(input int w, input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL w%0d %s: got 0x%0h, expected 0x%0h", w, name, act, exp);
      end
   endtask

   function automatic item_t mk(input bit r, input bit s, input longint a, input longint b,
                                input logic [2:0] sel, input bit c);
      item_t it;
      it.rst = r;
      it.st  = s;
      it.a   = a;
      it.b   = b;
      it.sel = sel;
      it.ctl = c;
      return it;
   endfunction

   // Reference model: interpret the operands as mathematical integers, do the
   // operation exactly, then wrap to w bits.
   function automatic exp_t model(input int w, input longint ua, input longint ub,
                                  input logic [2:0] sel, input bit ctl);
      exp_t   e;
      longint m, half, xs, ys, r;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      xs   = (ua >= half) ? ua - (half << 1) : ua;
      ys   = (ub >= half) ? ub - (half << 1) : ub;
      e.ovf = 1'b0;
      e.dz  = 1'b0;
      e.due = 0;
      r     = 0;
      case (sel)
         3'b000: begin
            r     = xs + ys;
            e.ovf = (r < -half) || (r >= half);
         end
         3'b001: begin
            if (ctl) begin
               r = (xs < ys) ? 64'sd1 : 64'sd0;
            end else begin
               r     = xs - ys;
               e.ovf = (r < -half) || (r >= half);
            end
         end
         3'b010: r = xs * ys;
         3'b011: begin
            if (ys == 0) begin
               r    = -64'sd1;
               e.dz = 1'b1;
            end else begin
               r = xs / ys;
            end
         end
         3'b100: r = ua & ub;
         3'b101: r = ua | ub;
         3'b110: r = ua ^ ub;
         default: r = ~(ua | ub);
      endcase
      e.res = r & m;
      e.zf  = (e.res == 64'sd0);
      return e;
   endfunction

   // Random operand with a bias towards the corner values.
   function automatic longint pick(input int w);
      longint m, half;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      case ($urandom_range(0, 7))
         0: return 64'sd0;
         1: return half;
         2: return m;
         3: return half - 1;
         4: return 64'sd1;
         default: return longint'({$urandom, $urandom}) & m;
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_blk
      localparam int W = (g == 0) ? 32 : 8;

      logic         rst_n   = 1'b0;
      logic         start   = 1'b0;
      logic [W-1:0] a       = '0;
      logic [W-1:0] b       = '0;
      logic         control = 1'b0;
      logic [2:0]   sel     = 3'b000;
      logic         busy, done, zf, ovf, dz;
      logic [W-1:0] res;

      int     cyc      = 0;
      int     bsy_left = 0;
      bit     exp_busy = 1'b0;
      bit     exp_rst  = 1'b1;
      bit     fin      = 1'b0;
      exp_t   sb[$];
      item_t  items[$];
      exp_t   e;
      exp_t   got;
      longint m, half;
      longint pa, pb;

      alu_seq #(.WIDTH(W)) u_dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .start  (start),
         .A      (a),
         .B      (b),
         .control(control),
         .sel    (sel),
         .busy   (busy),
         .done   (done),
         .res    (res),
         .zf     (zf),
         .ovf    (ovf),
         .dz     (dz)
      );

      always @(posedge clk) cyc <= cyc + 1;

      // Driver
      initial begin
         m    = (longint'(1) << W) - 1;
         half = longint'(1) << (W - 1);
         pa   = 64'h5A5A5A5A & m;
         pb   = 64'h0FF00FF0 & m;

         items.push_back(mk(1, 0, 0, 0, 3'b000, 0));
         items.push_back(mk(1, 0, 0, 0, 3'b000, 0));
         items.push_back(mk(0, 0, 0, 0, 3'b000, 0));
         // add/sub/slt corners
         items.push_back(mk(0, 1, half - 1, 1, 3'b000, 0));
         items.push_back(mk(0, 1, 5, 5, 3'b001, 0));
         items.push_back(mk(0, 1, half, 1, 3'b001, 1));
         items.push_back(mk(0, 1, 3, m - 1, 3'b001, 1));
         items.push_back(mk(0, 1, 3, m - 1, 3'b001, 0));
         // logic ops back to back
         for (int j = 4; j < 8; j++) items.push_back(mk(0, 1, pa, pb, 3'(j), 0));
         // -7 * 6, with start pulses that must be ignored while busy
         items.push_back(mk(0, 1, m - 6, 6, 3'b010, 0));
         for (int j = 0; j < W + 1; j++) items.push_back(mk(0, (j % 3) == 1, j, 2, 3'b000, 0));
         // -7 / 2, then MIN / -1, then 9 / 0 accepted in the done cycle
         items.push_back(mk(0, 1, m - 6, 2, 3'b011, 0));
         for (int j = 0; j < W + 1; j++) items.push_back(mk(0, 0, 0, 0, 3'b000, 0));
         items.push_back(mk(0, 1, half, m, 3'b011, 0));
         for (int j = 0; j < W + 1; j++) items.push_back(mk(0, 0, 1, 1, 3'b010, 0));
         items.push_back(mk(0, 1, 9, 0, 3'b011, 0));
         items.push_back(mk(0, 1, 7, 0, 3'b011, 0));
         items.push_back(mk(0, 1, 0, 0, 3'b000, 0));
         // reset held two edges in the middle of a multiply
         items.push_back(mk(0, 1, 3, 4, 3'b010, 0));
         for (int j = 0; j < 5; j++) items.push_back(mk(0, 0, 0, 0, 3'b000, 0));
         items.push_back(mk(1, 0, 0, 0, 3'b000, 0));
         items.push_back(mk(1, 0, 0, 0, 3'b000, 0));
         for (int j = 0; j < W + 4; j++) items.push_back(mk(0, 0, 0, 0, 3'b000, 0));
         // random traffic: random spacing, operands changing after start
         for (int j = 0; j < 1200; j++) begin
            items.push_back(mk($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                               pick(W), pick(W), 3'($urandom_range(0, 7)),
                               $urandom_range(0, 1) == 1));
         end
         for (int j = 0; j < W + 4; j++) items.push_back(mk(0, 0, 0, 0, 3'b000, 0));

         foreach (items[i]) begin
            @(negedge clk);
            exp_rst = items[i].rst;
            if (items[i].rst) begin
               rst_n    = 1'b0;
               start    = 1'b0;
               bsy_left = 0;
               exp_busy = 1'b0;
               sb.delete();
            end else begin
               rst_n   = 1'b1;
               start   = items[i].st;
               a       = items[i].a[W-1:0];
               b       = items[i].b[W-1:0];
               sel     = items[i].sel;
               control = items[i].ctl;
               if (bsy_left > 0) begin
                  bsy_left--;
                  exp_busy = (bsy_left > 0);
               end else if (items[i].st) begin
                  e = model(W, items[i].a & m, items[i].b & m, items[i].sel, items[i].ctl);
                  if (items[i].sel == 3'b010 ||
                      (items[i].sel == 3'b011 && (items[i].b & m) != 0)) begin
                     bsy_left = W + 1;
                     exp_busy = 1'b1;
                     e.due    = cyc + W + 2;
                  end else begin
                     exp_busy = 1'b0;
                     e.due    = cyc + 1;
                  end
                  sb.push_back(e);
               end else begin
                  exp_busy = 1'b0;
               end
            end
         end
         @(negedge clk);
         fin = 1'b1;
      end

      // Monitor
      initial forever begin
         @(posedge clk);
         #1;
         if (exp_rst) begin
            check(W, "reset_res", longint'(res), 0);
            check(W, "reset_zf", longint'(zf), 1);
            check(W, "reset_ovf", longint'(ovf), 0);
            check(W, "reset_dz", longint'(dz), 0);
         end
         check(W, "busy", longint'(busy), longint'(exp_busy));
         if (sb.size() > 0 && sb[0].due == cyc) begin
            got = sb.pop_front();
            check(W, "done", longint'(done), 1);
            check(W, "res", longint'(res), got.res);
            check(W, "zf", longint'(zf), longint'(got.zf));
            check(W, "ovf", longint'(ovf), longint'(got.ovf));
            check(W, "dz", longint'(dz), longint'(got.dz));
         end else begin
            check(W, "no_done", longint'(done), 0);
         end
      end
   end

   initial begin
      wait (g_blk[0].fin && g_blk[1].fin);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_checks, n_fail);
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the CPU's combinational ALU. Keeps the same 3-bit operation encoding and set-less-than mode, adds a start/busy/done handshake, iterative signed multiply and divide, and zero/overflow/divide-by-zero flags. Sits in the execute stage: the control unit issues `start` with operands and stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥ 4)
- `CW`, $clog2(WIDTH)+1, iteration-counter width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  request; sampled only when `busy`=0
- `A`  in  WIDTH  signed operand A
- `B`  in  WIDTH  signed operand B
- `control`  in  1  with `sel`=001: 1 = set-less-than, 0 = subtract
- `sel`  in  3  000 add, 001 sub/slt, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 nor
- `busy`  out  1  operation in progress; new `start` ignored
- `done`  out  1  one-cycle pulse; `res` and flags valid from this cycle
- `res`  out  WIDTH  signed result, held until the next `done`
- `zf`  out  1  `res` == 0
- `ovf`  out  1  signed overflow (add/sub only, else 0)
- `dz`  out  1  divide by zero (div only, else 0)

## Operation
- FSM states: IDLE, RUN, FIX. Counter `cnt` [CW-1:0].
- IDLE, `start`=1: A, B, sel, control captured into internal registers; later input changes have no effect.
  - add, sub, slt, and, or, xor, nor: result computed, registered, `done` pulsed; stay IDLE.
  - div with B == 0: `res` = all ones, `dz`=1, `done` pulsed; stay IDLE.
  - mul, div (B ≠ 0): go RUN, `busy`=1, `cnt`=0.
- RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle on operand magnitudes; `cnt` increments; after step WIDTH-1 go FIX.
- FIX: sign correction applied, `res` registered, `done` pulsed, `busy`=0, go IDLE.
- Arithmetic rules:
  - add/sub: WIDTH-bit two's-complement wrap; `ovf` = operand signs agree (sub: A and ~B) and result sign differs.
  - slt: `res` = 1 if A < B signed, else 0; exact comparison, no overflow error; `ovf`=0.
  - mul: low WIDTH bits of the signed 2·WIDTH product.
  - div: quotient truncated toward zero; MIN / -1 = MIN (wrap), `ovf`=0.
  - logic ops: bitwise; nor = ~(A|B).
- `zf` = (`res` == 0) for every operation, including slt and div-by-zero.
- Flags and `res` update only together with `done`.
- Reset (`rst_n`=0 at a clock edge): state IDLE, `cnt`=0, `busy`=0, `done`=0, `res`=0, `zf`=1, `ovf`=0, `dz`=0. Reset mid-RUN/FIX aborts with no `done`.

## Timing
- `start` sampled at edge k.
- Single-cycle ops and div-by-zero: `done`=1 during cycle k+1, `busy` stays 0; back-to-back `start` every cycle accepted.
- mul/div: `busy`=1 from edge k through cycle k+WIDTH+1; `done`=1 and `busy`=0 after edge k+WIDTH+1; latency WIDTH+1 (33 at WIDTH=32).
- `start` in the same cycle `done` is high (state IDLE) is accepted.
- `start` while `busy`=1: ignored, no queuing.
- `done` never high for more than one consecutive cycle per request.

## Test plan
- Reset: hold `rst_n`=0 two edges mid-mul -> `busy`=0, `done` never pulses, `res`=0, `zf`=1.
- add 0x7FFFFFFF + 1 -> `done` at k+1, `res`=0x80000000, `ovf`=1, `zf`=0; sub 5-5 -> `res`=0, `zf`=1, `ovf`=0.
- slt A=0x80000000, B=1, control=1 -> `res`=1; A=3, B=-2 -> `res`=0, `zf`=1; control=0 same operands -> `res`=5.
- mul -7 × 6 -> `busy` 33 cycles, `done` at k+33, `res`=0xFFFFFFD6 (-42); `start` pulses during busy ignored.
- div -7 / 2 -> `res`=-3; 0x80000000 / -1 -> `res`=0x80000000, `ovf`=0; 9 / 0 -> `done` at k+1, `res`=0xFFFFFFFF, `dz`=1.
- Random ops at WIDTH=8 and WIDTH=32 against a reference model, random `start` spacing and operand changes after `start` -> every result and flag matches, exactly one `done` per accepted `start`.
